// File: rtl/calcn_core.sv
// Multi-port request/response calculator: per-port request queues, a round-robin
// arbiter feeding one execute stage, results returned on the originating port.
module calcn_core #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned DW     = 32,
  parameter int unsigned TAGW   = 2,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                   c_clk,
  input  logic                   reset,
  input  logic [NPORTS*4-1:0]    req_cmd,
  input  logic [NPORTS*DW-1:0]   req_d1,
  input  logic [NPORTS*DW-1:0]   req_d2,
  input  logic [NPORTS*TAGW-1:0] req_tag,
  output logic [NPORTS-1:0]      req_busy,
  output logic [NPORTS*2-1:0]    out_resp,
  output logic [NPORTS*DW-1:0]   out_data,
  output logic [NPORTS*TAGW-1:0] out_tag,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned QW = $clog2(QDEPTH);
  localparam int unsigned CW = QW + 1;
  localparam int unsigned SW = $clog2(DW);

  typedef struct packed {
    logic [3:0]      cmd;
    logic [DW-1:0]   d1;
    logic [DW-1:0]   d2;
    logic [TAGW-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  entry_t                fifo_q   [NPORTS][QDEPTH];
  entry_t                fifo_d   [NPORTS][QDEPTH];
  logic   [QW-1:0]       wr_ptr_q [NPORTS];
  logic   [QW-1:0]       wr_ptr_d [NPORTS];
  logic   [QW-1:0]       rd_ptr_q [NPORTS];
  logic   [QW-1:0]       rd_ptr_d [NPORTS];
  logic   [CW-1:0]       cnt_q    [NPORTS];
  logic   [CW-1:0]       cnt_d    [NPORTS];
  logic   [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic   [7:0]          drop_cnt_q, drop_cnt_d;
  logic                  ex_vld_q, ex_vld_d;
  logic   [PW-1:0]       ex_port_q, ex_port_d;
  entry_t                ex_q, ex_d;
  logic [NPORTS*2-1:0]    out_resp_q, out_resp_d;
  logic [NPORTS*DW-1:0]   out_data_q, out_data_d;
  logic [NPORTS*TAGW-1:0] out_tag_q, out_tag_d;

  logic [NPORTS-1:0] busy, push, pop;
  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  logic [3:0]        ndrop;
  logic [8:0]        drop_sum;
  logic [DW:0]       sum;
  resp_e             res_resp;
  logic [DW-1:0]     res_data;

  // Busy comes only from the registered count, so a pop in the same cycle cannot free a slot.
  always_comb begin
    busy  = '0;
    push  = '0;
    ndrop = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      busy[i] = (cnt_q[i] == CW'(QDEPTH));
      push[i] = (req_cmd[i*4 +: 4] != 4'd0) && !busy[i];
      if ((req_cmd[i*4 +: 4] != 4'd0) && busy[i]) ndrop = ndrop + 4'd1;
    end
    drop_sum   = {1'b0, drop_cnt_q} + 9'(ndrop);
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_ptr_d  = rr_ptr_q;
    pop       = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      idx = (32'(rr_ptr_q) + k) % NPORTS;
      if (!grant_vld && (cnt_q[idx] != '0)) begin
        grant_vld = 1'b1;
        grant_idx = PW'(idx);
        rr_ptr_d  = PW'((idx + 1) % NPORTS);
        pop[idx]  = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (push[i]) begin
        fifo_d[i][wr_ptr_q[i]].cmd = req_cmd[i*4 +: 4];
        fifo_d[i][wr_ptr_q[i]].d1  = req_d1[i*DW +: DW];
        fifo_d[i][wr_ptr_q[i]].d2  = req_d2[i*DW +: DW];
        fifo_d[i][wr_ptr_q[i]].tag = req_tag[i*TAGW +: TAGW];
        wr_ptr_d[i] = wr_ptr_q[i] + QW'(1);
      end
      if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + QW'(1);
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    ex_vld_d  = grant_vld;
    ex_port_d = grant_idx;
    ex_d      = '0;
    if (grant_vld) ex_d = fifo_q[grant_idx][rd_ptr_q[grant_idx]];
  end

  always_comb begin
    res_resp = RESP_ERR;
    res_data = '0;
    sum      = {1'b0, ex_q.d1} + {1'b0, ex_q.d2};
    case (ex_q.cmd)
      4'd1: if (!sum[DW]) begin
        res_resp = RESP_OK;
        res_data = sum[DW-1:0];
      end
      4'd2: if (ex_q.d2 <= ex_q.d1) begin
        res_resp = RESP_OK;
        res_data = ex_q.d1 - ex_q.d2;
      end
      4'd5: begin
        res_resp = RESP_OK;
        res_data = ex_q.d1 << ex_q.d2[SW-1:0];
      end
      4'd6: begin
        res_resp = RESP_OK;
        res_data = ex_q.d1 >> ex_q.d2[SW-1:0];
      end
      default: begin
        res_resp = RESP_ERR;
        res_data = '0;
      end
    endcase
  end

  always_comb begin
    out_resp_d = '0;
    out_data_d = '0;
    out_tag_d  = '0;
    if (ex_vld_q) begin
      out_resp_d[32'(ex_port_q)*2 +: 2]       = res_resp;
      out_data_d[32'(ex_port_q)*DW +: DW]     = res_data;
      out_tag_d[32'(ex_port_q)*TAGW +: TAGW]  = ex_q.tag;
    end
  end

  // Queue storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge c_clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NPORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
      ex_vld_q   <= 1'b0;
      ex_port_q  <= '0;
      ex_q       <= '0;
      out_resp_q <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      ex_vld_q   <= ex_vld_d;
      ex_port_q  <= ex_port_d;
      ex_q       <= ex_d;
      out_resp_q <= out_resp_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign req_busy = busy;
  assign out_resp = out_resp_q;
  assign out_data = out_data_q;
  assign out_tag  = out_tag_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_calcn_core.sv
// Directed bench for calcn_core: fixed-latency checks plus a per-port in-order response scoreboard.
module tb_calcn_core;
  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 2;
  localparam int unsigned QD = 4;

  logic             c_clk = 1'b0;
  logic             reset;
  logic [NP*4-1:0]  req_cmd;
  logic [NP*DW-1:0] req_d1, req_d2;
  logic [NP*TW-1:0] req_tag;
  logic [NP-1:0]    req_busy;
  logic [NP*2-1:0]  out_resp;
  logic [NP*DW-1:0] out_data;
  logic [NP*TW-1:0] out_tag;
  logic [7:0]       drop_cnt;

  calcn_core #(.NPORTS(NP), .DW(DW), .TAGW(TW), .QDEPTH(QD)) dut (
    .c_clk(c_clk), .reset(reset), .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2),
    .req_tag(req_tag), .req_busy(req_busy), .out_resp(out_resp), .out_data(out_data),
    .out_tag(out_tag), .drop_cnt(drop_cnt)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } exp_t;

  exp_t expq [$];
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic clr();
    req_cmd = '0;
    req_d1  = '0;
    req_d2  = '0;
    req_tag = '0;
  endtask

  task automatic set_req(input int p, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] t);
    req_cmd[p*4 +: 4]   = cmd;
    req_d1[p*DW +: DW]  = a;
    req_d2[p*DW +: DW]  = b;
    req_tag[p*TW +: TW] = t;
  endtask

  task automatic expect_rsp(input int p, input logic [1:0] r, input logic [31:0] d,
                            input logic [1:0] t);
    exp_t e;
    e.port = p;
    e.resp = r;
    e.data = d;
    e.tag  = t;
    expq.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr();
    expq.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: the first outstanding entry for a port must match that port's response.
  always @(negedge c_clk) begin
    int nresp;
    int idx;
    logic [1:0] r;
    nresp = 0;
    if (mon_en) begin
      for (int p = 0; p < int'(NP); p++) begin
        r = out_resp[p*2 +: 2];
        if (r != 2'd0) begin
          nresp++;
          idx = -1;
          for (int k = 0; k < expq.size(); k++) begin
            if (expq[k].port == p) begin
              idx = k;
              break;
            end
          end
          if (idx < 0) begin
            chk($sformatf("unexp_p%0d", p), 64'(r), 64'(0));
          end else begin
            chk($sformatf("rsp_p%0d", p), {r, out_tag[p*TW +: TW], out_data[p*DW +: DW]},
                {expq[idx].resp, expq[idx].tag, expq[idx].data});
            expq.delete(idx);
          end
        end
      end
      if (nresp != 0) chk("onehot", 64'(nresp), 64'(1));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  logic [3:0]  vc [5];
  logic [31:0] va [5], vb [5], vd [5];
  logic [1:0]  vr [5];

  initial begin
    clr();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", 64'(req_busy), 64'(0));
    chk("rst_resp", 64'(out_resp), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_tag",  64'(out_tag),  64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single add with two-edge latency and one-cycle output pulse
    set_req(0, 4'd1, 32'd5, 32'd7, 2'd2);
    expect_rsp(0, 2'd1, 32'd12, 2'd2);
    tick();
    clr();
    tick();
    chk("add_early", 64'(out_resp), 64'(0));
    tick();
    chk("add_resp", 64'(out_resp), 64'h01);
    chk("add_data", 64'(out_data[31:0]), 64'd12);
    chk("add_tag",  64'(out_tag[1:0]), 64'd2);
    tick();
    chk("add_pulse", 64'(out_resp), 64'(0));
    chk("add_clear", 64'(out_data), 64'(0));

    // Port 1: carry overflow, sub underflow, logical shift right with masked amount
    set_req(1, 4'd1, 32'hFFFF_FFFF, 32'd1, 2'd1);
    expect_rsp(1, 2'd2, 32'd0, 2'd1);
    tick();
    set_req(1, 4'd2, 32'd3, 32'd4, 2'd2);
    expect_rsp(1, 2'd2, 32'd0, 2'd2);
    tick();
    set_req(1, 4'd6, 32'h80, 32'h23, 2'd3);
    expect_rsp(1, 2'd1, 32'h10, 2'd3);
    tick();
    clr();
    chk("ovf_resp", 64'(out_resp), 64'h08);
    chk("ovf_data", 64'(out_data[63:32]), 64'd0);
    tick();
    chk("sub_err", 64'(out_resp), 64'h08);
    chk("sub_tag", 64'(out_tag[3:2]), 64'd2);
    tick();
    chk("shr_resp", 64'(out_resp), 64'h04);
    chk("shr_data", 64'(out_data[63:32]), 64'h10);

    // Port 3 back-to-back vector table
    vc = '{4'd5, 4'd2, 4'd7, 4'd1, 4'd2};
    va = '{32'd1, 32'd9, 32'd1, 32'hFFFF_FFFE, 32'd4};
    vb = '{32'h21, 32'd4, 32'd1, 32'd1, 32'd4};
    vr = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1};
    vd = '{32'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd0};
    for (int i = 0; i < 5; i++) begin
      set_req(3, vc[i], va[i], vb[i], 2'(i));
      expect_rsp(3, vr[i], vd[i], 2'(i));
      tick();
    end
    clr();
    for (int i = 0; i < 8; i++) tick();
    chk("tbl_drain", 64'(expq.size()), 64'(0));

    // Two simultaneous bursts: round-robin starts at port 0 both times
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < int'(NP); p++) begin
        set_req(p, 4'd1, 32'(p + 1), 32'(10 * b), 2'(p));
        expect_rsp(p, 2'd1, 32'(p + 1 + 10 * b), 2'(p));
      end
      tick();
      clr();
      tick();
      for (int j = 0; j < int'(NP); j++) begin
        tick();
        chk($sformatf("rr_b%0d_%0d", b, j), 64'(out_resp), 64'(8'h01 << (2 * j)));
      end
    end

    // Port 2 overfill while the other ports keep arbitration busy
    do_reset();
    for (int e = 0; e < 6; e++) begin
      if (e == 4) chk("busy_e4", 64'(req_busy), 64'h8);
      if (e == 5) chk("busy_e5", 64'(req_busy), 64'h4);
      clr();
      for (int p = 0; p < int'(NP); p++) begin
        if (e < 4 || p == 2) begin
          set_req(p, 4'd1, 32'(p * 16 + e), 32'd1, 2'(e));
          if (!(p == 2 && e == 5)) expect_rsp(p, 2'd1, 32'(p * 16 + e + 1), 2'(e));
        end
      end
      tick();
    end
    clr();
    chk("drop_one", 64'(drop_cnt), 64'd1);
    chk("busy_e6", 64'(req_busy), 64'h4);
    for (int i = 0; i < 30; i++) tick();
    chk("fill_drain", 64'(expq.size()), 64'(0));
    chk("busy_idle", 64'(req_busy), 64'(0));

    // Drop counter saturation under sustained overload
    do_reset();
    mon_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      for (int p = 0; p < int'(NP); p++) set_req(p, 4'd1, 32'd1, 32'd1, 2'd0);
      tick();
    end
    clr();
    chk("drop_sat", 64'(drop_cnt), 64'd255);
    do_reset();
    mon_en = 1'b1;

    // Reset with queued work, plus a request presented during reset
    for (int p = 0; p < 3; p++) set_req(p, 4'd1, 32'd7, 32'd7, 2'd1);
    tick();
    clr();
    reset = 1'b1;
    set_req(3, 4'd1, 32'd2, 32'd2, 2'd3);
    #1;
    chk("mid_rst_resp", 64'(out_resp), 64'(0));
    tick();
    tick();
    chk("mid_rst_busy", 64'(req_busy), 64'(0));
    chk("mid_rst_drop", 64'(drop_cnt), 64'(0));
    chk("mid_rst_data", 64'(out_data), 64'(0));
    clr();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("post_rst_%0d", i), 64'(out_resp), 64'(0));
    end
    set_req(1, 4'd1, 32'd100, 32'd23, 2'd3);
    expect_rsp(1, 2'd1, 32'd123, 2'd3);
    tick();
    clr();
    tick();
    chk("post_early", 64'(out_resp), 64'(0));
    tick();
    chk("post_resp", 64'(out_resp), 64'h04);
    chk("post_data", 64'(out_data[63:32]), 64'd123);
    tick();
    chk("post_pulse", 64'(out_resp), 64'(0));
    chk("sb_empty", 64'(expq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/calcn_core.md
CALCN_CORE -- requirements
Module: calcn_core

Interface
REQ-001 SHALL have parameter NPORTS, default 4, number of request/response channels (2..8).
REQ-002 SHALL have parameter DW, default 32, operand/result width (power of 2, 8..64).
REQ-003 SHALL have parameter TAGW, default 2, tag width.
REQ-004 SHALL have parameter QDEPTH, default 4, per-port request queue depth (power of 2, >=2).
REQ-005 SHALL have port c_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_cmd  input  NPORTS*4  per-port command; 0 = no request.
REQ-008 SHALL have port req_d1  input  NPORTS*DW  per-port operand 1.
REQ-009 SHALL have port req_d2  input  NPORTS*DW  per-port operand 2.
REQ-010 SHALL have port req_tag  input  NPORTS*TAGW  per-port request tag.
REQ-011 SHALL have port req_busy  output  NPORTS  per-port queue full.
REQ-012 SHALL have port out_resp  output  NPORTS*2  per-port response code: 0 none, 1 success, 2 error.
REQ-013 SHALL have port out_data  output  NPORTS*DW  per-port result.
REQ-014 SHALL have port out_tag  output  NPORTS*TAGW  per-port echoed tag.
REQ-015 SHALL have port drop_cnt  output  8  saturating count of requests rejected while busy.

Function
REQ-016 Port i SHALL use slice [i*W +: W] of every flattened bus.
REQ-017 A request on port i SHALL be accepted at a rising edge when req_cmd[i]!=0 and req_busy[i]==0; cmd, d1, d2, tag pushed into port i FIFO.
REQ-018 req_busy[i] SHALL equal (count[i]==QDEPTH), driven from registered count, no combinational input path.
REQ-019 Request presented while busy SHALL be discarded, produce no response, and increment drop_cnt (saturate at 255).
REQ-020 Simultaneous pop and push on a full FIFO SHALL still reject the push (busy reflects pre-pop count).
REQ-021 Each cycle a round-robin arbiter SHALL pop one non-empty FIFO into the execute register; search starts at rr_ptr, rr_ptr updates to (grantee+1) mod NPORTS; rr_ptr unchanged when all empty.
REQ-022 Commands: 1 add, 2 sub, 5 shift left, 6 shift right; any other nonzero code SHALL give resp 2, data 0.
REQ-023 Add with carry out of bit DW-1 SHALL give resp 2, data 0.
REQ-024 Sub with d2>d1 (unsigned) SHALL give resp 2, data 0.
REQ-025 Shifts SHALL be logical by d2[log2(DW)-1:0]; upper d2 bits ignored; always resp 1.
REQ-026 Result SHALL appear on the originating port's out_* for exactly one cycle, at edge k+2 after acceptance at edge k when the port wins arbitration at edge k+1; latency grows by queueing/arbitration only.
REQ-027 When no result is delivered, out_resp[i] SHALL be 0 and out_data/out_tag[i] SHALL be 0.
REQ-028 Per-port responses SHALL be returned in acceptance order; tags are echoed, not checked for uniqueness.
REQ-029 At most one port SHALL have nonzero out_resp in any cycle.
REQ-030 FIFO pointers SHALL wrap modulo QDEPTH without loss or duplication.

Reset
REQ-031 While reset is high, all FIFOs SHALL be emptied, execute/output registers cleared, rr_ptr=0, drop_cnt=0, req_busy=0, all out_* = 0.
REQ-032 Reset asserted mid-operation SHALL discard queued and in-flight requests; no response SHALL appear for them after deassertion.
REQ-033 No request SHALL be accepted on an edge where reset is high.

Verification
REQ-034 Port 0 cmd 1, d1=5, d2=7, tag 2 -> two edges later out_resp[0]=1, out_data[0]=12, out_tag[0]=2 for one cycle.
REQ-035 Port 1 cmd 1, d1=0xFFFFFFFF, d2=1 -> resp 2, data 0; cmd 2, d1=3, d2=4 -> resp 2; cmd 6, d1=0x80, d2=0x23 -> resp 1, data 0x10.
REQ-036 All 4 ports issue cmd 1 same edge -> results on ports 0,1,2,3 in consecutive cycles; next simultaneous burst starts at port 0 again (rr_ptr wrapped).
REQ-037 Port 2 sent QDEPTH+2 requests while port 0 saturates arbitration -> req_busy[2] rises after QDEPTH accepts, drop_cnt counts rejects, accepted results return in order.
REQ-038 Reset pulse with 3 requests queued -> all outputs 0, no responses afterwards, next request answered with 2-edge latency.
